// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers used by the iterative cipher core.
package aes_pkg;
  localparam logic [3:0] NR = 4'd10;

  typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entries 1..10 are the real round constants; the padding keeps any 4-bit index in range.
  localparam logic [0:15][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Multiples 9, 11, 13, 14 are built from the doubling chain x2/x4/x8.
  function automatic logic [31:0] inv_mix_column(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// One AES-128 round-key step: forward (dir=0, Rcon[round]) or inverse (dir=1, Rcon[11-round]).
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] rk,
  input  logic [3:0]   round,
  input  logic         dir,
  output logic [127:0] rk_next
);
  logic [3:0]  rcon_idx;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] f0, f1, f2, f3;
  logic [31:0] p1, p2, p3, p0;
  logic [31:0] rcon_word;

  always_comb begin
    rcon_idx  = dir ? (4'd11 - round) : round;
    rcon_word = {RCON[rcon_idx], 24'h0};
    {w0, w1, w2, w3} = rk;
    f0 = w0 ^ sub_word({w3[23:0], w3[31:24]}) ^ rcon_word;
    f1 = w1 ^ f0;
    f2 = w2 ^ f1;
    f3 = w3 ^ f2;
    // Undo the XOR chain first so the previous last word can feed RotWord/SubWord.
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ rcon_word;
    rk_next = dir ? {p0, p1, p2, p3} : {f0, f1, f2, f3};
  end
endmodule

// File: rtl/encrypter_aes.sv
// Iterative AES-128 encrypt/decrypt core: one round per clock, decrypt pre-expands to rk10.
module encrypter_aes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);
  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d, rk_q, rk_d, data_q, data_d, data_out_q, data_out_d;
  logic [3:0]   round_q, round_d;
  logic         dec_q, dec_d, busy_q, busy_d, done_q, done_d;

  logic [127:0] rk_step, enc_sr, enc_mc, enc_next, dec_sr, dec_ark, dec_imc, dec_next;
  logic         last_round;

  aes_key_step u_key_step (
    .rk      (rk_q),
    .round   (round_q),
    .dir     (fsm_q == ROUND && dec_q),
    .rk_next (rk_step)
  );

  // Byte i sits at row i%4, column i/4; ShiftRows is folded into the S-box source index.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int FWD = 4 * ((COL + ROW) % 4) + ROW;
    localparam int INV = 4 * ((COL + 4 - ROW) % 4) + ROW;
    assign enc_sr[127-8*gi -: 8] = SBOX[state_q[127-8*FWD -: 8]];
    assign dec_sr[127-8*gi -: 8] = INV_SBOX[state_q[127-8*INV -: 8]];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign enc_mc[127-32*gi -: 32]  = mix_column(enc_sr[127-32*gi -: 32]);
    assign dec_imc[127-32*gi -: 32] = inv_mix_column(dec_ark[127-32*gi -: 32]);
  end

  assign last_round = (round_q == NR);
  assign enc_next   = (last_round ? enc_sr : enc_mc) ^ rk_step;
  assign dec_ark    = dec_sr ^ rk_step;
  assign dec_next   = last_round ? dec_ark : dec_imc;

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    rk_d       = rk_q;
    data_d     = data_q;
    data_out_d = data_out_q;
    round_d    = round_q;
    dec_d      = dec_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          dec_d   = decrypt;
          data_d  = data_in;
          rk_d    = key_in;
          round_d = 4'd1;
          busy_d  = 1'b1;
          if (decrypt) begin
            fsm_d = KEXP;
          end else begin
            state_d = data_in ^ key_in;
            fsm_d   = ROUND;
          end
        end
      end
      KEXP: begin
        rk_d    = rk_step;
        round_d = last_round ? 4'd1 : round_q + 4'd1;
        if (last_round) fsm_d = INIT;
      end
      INIT: begin
        state_d = data_q ^ rk_q;
        round_d = 4'd1;
        fsm_d   = ROUND;
      end
      ROUND: begin
        rk_d    = rk_step;
        state_d = dec_q ? dec_next : enc_next;
        round_d = round_q + 4'd1;
        if (last_round) begin
          data_out_d = state_d;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          fsm_d      = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      rk_q       <= '0;
      data_q     <= '0;
      data_out_q <= '0;
      round_q    <= '0;
      dec_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      rk_q       <= rk_d;
      data_q     <= data_d;
      data_out_q <= data_out_d;
      round_q    <= round_d;
      dec_q      <= dec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_encrypter_aes.sv
// Directed + randomized bench for encrypter_aes against a textbook byte-array AES model.
module tb_encrypter_aes;
  logic         clk = 1'b0;
  logic         reset, start, decrypt;
  logic [127:0] data_in, key_in, data_out;
  logic         busy, done;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  encrypter_aes dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .decrypt  (decrypt),
    .data_in  (data_in),
    .key_in   (key_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic dec, input logic [127:0] din,
                                           input logic [127:0] key);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rk [11][16];
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    logic [7:0]  m [4];
    logic [7:0]  acc;
    logic [127:0] out;
    int r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++)
      for (int i = 0; i < 16; i++) rk[k][i] = w[4*k + i/4][31-8*(i%4) -: 8];
    for (int i = 0; i < 16; i++) s[i] = din[127-8*i -: 8];
    if (dec) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 16; i++) s[i] ^= rk[dec ? 10 : 0][i];
    for (int step = 1; step <= 10; step++) begin
      r = dec ? 10 - step : step;
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          if (dec) t[4*((c+row)%4)+row] = isb[s[4*c+row]];
          else     t[4*c+row] = sb[s[4*((c+row)%4)+row]];
      s = t;
      if (dec) for (int i = 0; i < 16; i++) s[i] ^= rk[r][i];
      if ((!dec && step < 10) || (dec && r > 0)) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc ^= gmul(m[(j - row + 4) % 4], s[4*c+j]);
            t[4*c+row] = acc;
          end
        s = t;
      end
      if (!dec) for (int i = 0; i < 16; i++) s[i] ^= rk[r][i];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues a request and scrambles the inputs right after it is accepted.
  task automatic launch(input logic dec, input logic [127:0] d, input logic [127:0] k);
    start = 1'b1; decrypt = dec; data_in = d; key_in = k;
    @(posedge clk); #1;
    start = 1'b0; decrypt = ~dec; data_in = ~d; key_in = ~k;
    chk("busy_rise", 128'(busy), 128'(1));
  endtask

  task automatic await_done(input string tag, input int lat, input logic [127:0] exp);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 128'(n), 128'(lat));
    chk({tag, "_data"}, data_out, exp);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    $display("op %s: latency %0d data_out %h", tag, n, data_out);
  endtask

  task automatic count_done(input string tag, input int cycles);
    int cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done === 1'b1) cnt++;
    end
    chk(tag, 128'(cnt), 128'(0));
  endtask

  logic [127:0] k1, d1, ct, pt_ascii;
  logic         dec1;

  initial begin
    reset = 1'b0; start = 1'b0; decrypt = 1'b0; data_in = '0; key_in = '0;
    pt_ascii = "Discombobulateme";
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    launch(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f);
    await_done("fips_c1_enc", 10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(posedge clk); #1;
    chk("done_one_cycle", 128'(done), 128'(0));

    launch(1'b1, 128'h3925841d02dc09fbdc118597196a0b32, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    await_done("fips_b_dec", 21, 128'h3243f6a8885a308d313198a2e0370734);

    // Round trip, decrypt issued in the done cycle of the encrypt.
    @(posedge clk); #1;
    k1 = rnd128();
    ct = ref_aes(1'b0, pt_ascii, k1);
    launch(1'b0, pt_ascii, k1);
    await_done("rt_enc", 10, ct);
    launch(1'b1, ct, k1);
    await_done("rt_dec", 21, pt_ascii);

    for (int i = 0; i < 6; i++) begin
      dec1 = 1'($urandom_range(0, 1));
      d1 = rnd128();
      k1 = rnd128();
      launch(dec1, d1, k1);
      await_done(dec1 ? "rnd_dec" : "rnd_enc", dec1 ? 21 : 10, ref_aes(dec1, d1, k1));
    end

    // Requests while busy must be ignored entirely.
    @(posedge clk); #1;
    d1 = rnd128();
    k1 = rnd128();
    launch(1'b0, d1, k1);
    repeat (3) begin
      start = 1'b1; decrypt = 1'b1; data_in = rnd128(); key_in = rnd128();
      @(posedge clk); #1;
    end
    start = 1'b0;
    await_done("busy_ignore", 7, ref_aes(1'b0, d1, k1));
    count_done("busy_ignore_extra_done", 30);

    // Reset at the fifth cycle of a decrypt.
    launch(1'b1, rnd128(), rnd128());
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_done", 128'(done), 128'(0));
    chk("abort_data_out", data_out, 128'(0));
    $display("reset mid-decrypt: busy %b done %b data_out %h", busy, done, data_out);
    @(negedge clk); reset = 1'b1;
    count_done("abort_no_done", 30);
    @(negedge clk);
    d1 = rnd128();
    k1 = rnd128();
    launch(1'b1, d1, k1);
    await_done("post_reset_dec", 21, ref_aes(1'b1, d1, k1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
